// File: rtl/display_timing.sv
// -----------------------------------------------------------------------------
// display_timing
//
// Raster timing generator with a fixed-latency colour output stage.
//
// Free-running horizontal/vertical counters (h, v) describe the raster
// position. The position is exported undelayed on x/y so an upstream shader
// can compute a colour for it. The shader answers PIPE_DELAY cycles later on
// pix_r/g/b. The sync, active and colour-bar tags that belong to a position
// are delayed by the same PIPE_DELAY stages. The colour for the position is
// then registered onto the pins together with its syncs. Counter-to-pin
// latency is therefore PIPE_DELAY+1 cycles for every output.
//
// Ports
//   clk_pix      in   pixel clock, only clock of the block
//   resetn       in   asynchronous active-low reset
//   enable       in   1 = raster advances, 0 = counters and delay line hold
//   mode         in   0 shaded pixels, 1 solid white, 2 colour bars, 3 black
//                     (sampled once per frame, on frame_start)
//   pix_r/g/b    in   shaded colour for the x/y issued PIPE_DELAY cycles ago
//   x, y         out  raw horizontal / vertical counters
//   frame_start  out  one-cycle pulse while the counters sit at (0,0)
//   vga_r/g/b    out  registered colour
//   vga_hsync    out  registered horizontal sync, asserted level SYNC_POL
//   vga_vsync    out  registered vertical sync, asserted level SYNC_POL
//   vga_de       out  registered data-enable (visible pixel)
// -----------------------------------------------------------------------------
module display_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int PIPE_DELAY = 1
) (
    input  logic               clk_pix,
    input  logic               resetn,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic [10:0]        x,
    output logic [10:0]        y,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    // Bounds are held one bit wider than the counters so that a sync window
    // ending exactly at the total (zero back porch) still compares correctly.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] H_SS     = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_SS     = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE     = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_WHITE  = 2'd1;
    localparam logic [1:0] MODE_BARS   = 2'd2;
    localparam logic [1:0] MODE_BLACK  = 2'd3;

    // Per-position tags that travel down the delay line alongside the shader.
    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [2:0] bar;
    } tag_t;

    localparam tag_t TAG_IDLE = '{act: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, bar: 3'd0};

    // Colour selection for one pixel; inactive positions are always black.
    function automatic logic [3*COLOR_W-1:0] f_colour(
        input logic               act,
        input logic [1:0]         md,
        input logic [2:0]         bar,
        input logic [COLOR_W-1:0] sr,
        input logic [COLOR_W-1:0] sg,
        input logic [COLOR_W-1:0] sb
    );
        logic [3*COLOR_W-1:0] c;
        c = '0;
        if (act) begin
            case (md)
                MODE_NORMAL: c = {sr, sg, sb};
                MODE_WHITE:  c = '1;
                MODE_BARS:   c = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
                MODE_BLACK:  c = '0;
                default:     c = '0;
            endcase
        end
        return c;
    endfunction

    logic [10:0]          r_h;
    logic [10:0]          r_v;
    logic [11:0]          r_bar_cnt;
    logic [2:0]           r_bar;
    logic [1:0]           r_mode;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic                 w_frame_start;
    logic [1:0]           w_mode_out;
    tag_t                 w_tag_p0;
    tag_t                 w_tag_dly;
    logic [3*COLOR_W-1:0] w_colour;
    logic [COLOR_W-1:0]   r_vga_r;
    logic [COLOR_W-1:0]   r_vga_g;
    logic [COLOR_W-1:0]   r_vga_b;
    logic                 r_vga_hs;
    logic                 r_vga_vs;
    logic                 r_vga_de;

    assign w_h_wrap = ({1'b0, r_h} == H_LAST);
    assign w_v_wrap = ({1'b0, r_v} == V_LAST);

    // ---- stage p0: raster counters -----------------------------------------
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_h <= '0;
            r_v <= '0;
        end else if (enable) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= w_v_wrap ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    // Bar index is h / (H_ACTIVE/8) tracked incrementally: a segment counter
    // rolls every BAR_W pixels and bumps the index. Both clear when h wraps,
    // so they are aligned to h==0 on every line. Values past the active
    // region are ignored downstream.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_bar_cnt <= '0;
            r_bar     <= '0;
        end else if (enable) begin
            if (w_h_wrap) begin
                r_bar_cnt <= '0;
                r_bar     <= '0;
            end else if (r_bar_cnt == BAR_LAST) begin
                r_bar_cnt <= '0;
                r_bar     <= r_bar + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + 12'd1;
            end
        end
    end

    // resetn is folded in so the pulse stays low while reset holds the
    // counters at (0,0).
    assign w_frame_start = enable && resetn && (r_h == 11'd0) && (r_v == 11'd0);

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_mode <= MODE_NORMAL;
        end else if (w_frame_start) begin
            r_mode <= mode;
        end
    end

    // Zero-latency builds sample the first pixel of a frame in the same cycle
    // the mode is captured, so that pixel must see the incoming mode directly.
    assign w_mode_out = ((PIPE_DELAY == 0) && w_frame_start) ? mode : r_mode;

    assign w_tag_p0.act = ({1'b0, r_h} < H_ACT) && ({1'b0, r_v} < V_ACT);
    assign w_tag_p0.hs  = (({1'b0, r_h} >= H_SS) && ({1'b0, r_h} < H_SE)) ? SYNC_POL : ~SYNC_POL;
    assign w_tag_p0.vs  = (({1'b0, r_v} >= V_SS) && ({1'b0, r_v} < V_SE)) ? SYNC_POL : ~SYNC_POL;
    assign w_tag_p0.bar = r_bar;

    // ---- stages p1..pN: tag delay line matching shader latency -------------
    generate
        if (PIPE_DELAY == 0) begin : g_no_dly
            assign w_tag_dly = w_tag_p0;
        end else begin : g_dly
            tag_t r_tag_p [PIPE_DELAY];

            always_ff @(posedge clk_pix or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_tag_p[i] <= TAG_IDLE;
                    end
                end else if (enable) begin
                    r_tag_p[0] <= w_tag_p0;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_tag_p[i] <= r_tag_p[i-1];
                    end
                end
            end

            assign w_tag_dly = r_tag_p[PIPE_DELAY-1];
        end
    endgenerate

    assign w_colour = f_colour(w_tag_dly.act, w_mode_out, w_tag_dly.bar, pix_r, pix_g, pix_b);

    // ---- output register ---------------------------------------------------
    // While paused the pins go idle (blank, syncs deasserted) rather than
    // repeating a stale pixel; the held delay line resumes where it stopped.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
            r_vga_hs <= ~SYNC_POL;
            r_vga_vs <= ~SYNC_POL;
            r_vga_de <= 1'b0;
        end else if (!enable) begin
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
            r_vga_hs <= ~SYNC_POL;
            r_vga_vs <= ~SYNC_POL;
            r_vga_de <= 1'b0;
        end else begin
            {r_vga_r, r_vga_g, r_vga_b} <= w_colour;
            r_vga_hs <= w_tag_dly.hs;
            r_vga_vs <= w_tag_dly.vs;
            r_vga_de <= w_tag_dly.act;
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign frame_start = w_frame_start;
    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign vga_hsync   = r_vga_hs;
    assign vga_vsync   = r_vga_vs;
    assign vga_de      = r_vga_de;

endmodule
